writeback_arbiter: RTL and testbench

- Merges results from the single-cycle ALU and the long-latency load/multiply unit (LSU) onto the register file's single write port (addr_w/data_w/write_en).
- The ALU has fixed priority and never stalls.
- LSU results that collide with the ALU are held in a small FIFO. Write-after-write ordering to the same register is enforced.
- A pending-write query port feeds decode stall logic.

---
 rtl/cpu_pkg.sv | 11 +
 rtl/wb_fifo.sv | 63 ++++++
 rtl/writeback_arbiter.sv | 108 ++++++++++
 tb/tb_writeback_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared core types: register index/data widths and the writeback entry.
package cpu_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of LSU results with per-entry valid bits,
// squash-by-rd and a match-by-rd query.
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  wb_entry_t             push_entry,
    input  logic                  pop,
    input  logic                  squash_en,
    input  logic [REG_ADDR_W-1:0] squash_rd,
    input  logic [REG_ADDR_W-1:0] q_rd,
    output wb_entry_t             head,
    output logic [CW-1:0]         count,
    output logic                  q_match
);
    wb_entry_t         mem [DEPTH];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;

    assign head = mem[rptr];

    // Later assignments win: a push into the slot being popped keeps its entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squash_en && mem[i].rd == squash_rd) begin
                    mem[i].valid <= 1'b0;
                end
            end
            if (pop) begin
                mem[rptr].valid <= 1'b0;
                rptr <= rptr + 1'b1;
            end
            if (push) begin
                mem[wptr] <= push_entry;
                wptr <= wptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        q_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i].valid && mem[i].rd == q_rd) begin
                q_match = 1'b1;
            end
        end
    end
endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and LSU results onto the single register-file write port,
// ALU first, LSU results queued in order behind it.
module writeback_arbiter
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DATA_WIDTH = DATA_W,
    parameter int ADDR_WIDTH = REG_ADDR_W,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic [ADDR_WIDTH-1:0] addr_w,
    output logic [DATA_WIDTH-1:0] data_w,
    output logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] q_rd,
    output logic                  q_pending,
    output logic [CW-1:0]         fifo_count
);
    logic                  alu_hit;
    logic                  lsu_live;
    logic                  fifo_empty;
    logic                  pop;
    logic                  push;
    logic                  bypass;
    logic                  issue;
    logic [ADDR_WIDTH-1:0] iss_rd;
    logic [DATA_WIDTH-1:0] iss_data;
    logic                  q_match;
    wb_entry_t             head;
    wb_entry_t             push_entry;

    assign lsu_ready  = fifo_count < CW'(DEPTH);
    assign alu_hit    = alu_valid && alu_rd != '0;
    assign lsu_live   = lsu_valid && lsu_ready && lsu_rd != '0;
    assign fifo_empty = fifo_count == '0;

    always_comb begin
        pop      = 1'b0;
        bypass   = 1'b0;
        issue    = 1'b0;
        iss_rd   = alu_rd;
        iss_data = alu_data;
        priority case (1'b1)
            alu_hit: begin
                issue = 1'b1;
            end
            !fifo_empty: begin
                pop      = 1'b1;
                issue    = head.valid;
                iss_rd   = head.rd;
                iss_data = head.data;
            end
            lsu_live: begin
                bypass   = 1'b1;
                issue    = 1'b1;
                iss_rd   = lsu_rd;
                iss_data = lsu_data;
            end
            default: ;
        endcase
    end

    // A same-cycle LSU result to the ALU's rd is older, so it is dropped.
    assign push = lsu_live && !bypass && !(alu_hit && lsu_rd == alu_rd);

    assign push_entry = '{valid: 1'b1, rd: lsu_rd, data: lsu_data};

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_entry(push_entry),
        .pop       (pop),
        .squash_en (alu_hit),
        .squash_rd (alu_rd),
        .q_rd      (q_rd),
        .head      (head),
        .count     (fifo_count),
        .q_match   (q_match)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_en <= 1'b0;
            addr_w   <= '0;
            data_w   <= '0;
        end else begin
            write_en <= issue;
            if (issue) begin
                addr_w <= iss_rd;
                data_w <= iss_data;
            end
        end
    end

    assign q_pending = (q_rd != '0) &&
                       (q_match || (write_en && addr_w == q_rd));
endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized scoreboard bench for writeback_arbiter against a queue model.
module tb_writeback_arbiter;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alu_valid;
    logic [4:0]    alu_rd;
    logic [31:0]   alu_data;
    logic          lsu_valid;
    logic          lsu_ready;
    logic [4:0]    lsu_rd;
    logic [31:0]   lsu_data;
    logic [4:0]    addr_w;
    logic [31:0]   data_w;
    logic          write_en;
    logic [4:0]    q_rd;
    logic          q_pending;
    logic [CW-1:0] fifo_count;

    always #5 clk = ~clk;

    writeback_arbiter #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .addr_w    (addr_w),
        .data_w    (data_w),
        .write_en  (write_en),
        .q_rd      (q_rd),
        .q_pending (q_pending),
        .fifo_count(fifo_count)
    );

    typedef struct {
        bit        v;
        bit [4:0]  rd;
        bit [31:0] d;
    } ment_t;

    typedef struct {
        bit [4:0]  a;
        bit [31:0] d;
    } wr_t;

    ment_t     mq[$];
    wr_t       exp_q[$];
    bit        m_we;
    bit [4:0]  m_addr;
    bit [31:0] rf [32];
    int        errors = 0;
    int        checks = 0;
    bit        acc;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every DUT write must be the next expected one, in order.
    always @(negedge clk) begin
        if (rst_n && write_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got rd=%0d data=%0h expected none",
                         addr_w, data_w);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("wr_addr", addr_w, w.a);
                chk("wr_data", data_w, w.d);
            end
            rf[addr_w] = data_w;
        end
    end

    task automatic issue(input bit [4:0] rd, input bit [31:0] d);
        m_we   = 1'b1;
        m_addr = rd;
        exp_q.push_back('{a: rd, d: d});
    endtask

    task automatic step(input bit av, input bit [4:0] ar, input bit [31:0] ad,
                        input bit lv, input bit [4:0] lr, input bit [31:0] ld,
                        input bit [4:0] qr, output bit accepted);
        bit rdy;
        bit hit;
        bit pend;
        bit byp;
        @(negedge clk);
        chk("write_en", write_en, m_we);
        chk("fifo_count", fifo_count, mq.size());
        rdy = mq.size() < DEPTH;
        chk("lsu_ready", lsu_ready, rdy);
        alu_valid = av;
        alu_rd    = ar;
        alu_data  = ad;
        lsu_valid = lv;
        lsu_rd    = lr;
        lsu_data  = ld;
        q_rd      = qr;
        #1;
        pend = 1'b0;
        if (qr != 0) begin
            foreach (mq[i]) if (mq[i].v && mq[i].rd == qr) pend = 1'b1;
            if (m_we && m_addr == qr) pend = 1'b1;
        end
        chk("q_pending", q_pending, pend);
        accepted = lv && rdy;
        hit = av && ar != 0;
        byp = 1'b0;
        m_we = 1'b0;
        if (hit) begin
            foreach (mq[i]) if (mq[i].rd == ar) mq[i].v = 1'b0;
            issue(ar, ad);
        end else if (mq.size() > 0) begin
            ment_t e;
            e = mq.pop_front();
            if (e.v) issue(e.rd, e.d);
        end else if (accepted && lr != 0) begin
            issue(lr, ld);
            byp = 1'b1;
        end
        if (accepted && lr != 0 && !byp && !(hit && lr == ar))
            mq.push_back('{v: 1'b1, rd: lr, d: ld});
    endtask

    task automatic idle(input int n, input bit [4:0] qr);
        bit a;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, qr, a);
    endtask

    initial begin
        int cur;
        bit        lp_v;
        bit [4:0]  lp_rd;
        bit [31:0] lp_d;
        rst_n = 1'b0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        q_rd = 5'd5;
        #8;
        chk("rst_write_en", write_en, 0);
        chk("rst_addr_w", addr_w, 0);
        chk("rst_data_w", data_w, 0);
        chk("rst_lsu_ready", lsu_ready, 1);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_q_pending", q_pending, 0);
        #4 rst_n = 1'b1;

        step(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, acc);
        idle(2, 5);
        chk("alu_rf5", rf[5], 32'hDEADBEEF);

        step(0, 0, 0, 1, 7, 32'h1234, 7, acc);
        idle(2, 7);
        chk("bypass_rf7", rf[7], 32'h1234);

        cur = 1;
        for (int i = 0; i < 6; i++) begin
            step(1, 5'(20 + i), 32'h900 + i, cur <= 5, 5'(cur),
                 32'h100 + cur, 5'(cur), acc);
            if (acc) cur++;
        end
        chk("fill_count", fifo_count, 4);
        chk("fill_ready", lsu_ready, 0);
        while (cur <= 5) begin
            step(0, 0, 0, 1, 5'(cur), 32'h100 + cur, 3, acc);
            if (acc) cur++;
        end
        idle(6, 4);
        chk("drain_rf5", rf[5], 32'h105);

        step(1, 3, 32'h33, 1, 9, 32'h55, 9, acc);
        step(1, 9, 32'hAA, 0, 0, 0, 9, acc);
        idle(4, 9);
        chk("waw_rf9", rf[9], 32'hAA);

        step(1, 0, 32'h77, 1, 0, 32'h66, 0, acc);
        step(1, 12, 32'hC, 1, 13, 32'hD, 13, acc);
        step(1, 0, 32'h88, 0, 0, 0, 13, acc);
        idle(3, 13);
        chk("rd0_rf13", rf[13], 32'hD);

        step(1, 21, 32'h21, 1, 22, 32'h22, 22, acc);
        step(1, 23, 32'h23, 1, 24, 32'h24, 22, acc);
        step(1, 25, 32'h25, 1, 26, 32'h26, 24, acc);
        step(1, 27, 32'h27, 0, 0, 0, 26, acc);
        alu_valid = 0;
        lsu_valid = 0;
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_write_en", write_en, 0);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_q_pending", q_pending, 0);
        mq.delete();
        exp_q.delete();
        m_we = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        idle(4, 22);

        lp_v = 0; lp_rd = 0; lp_d = 0;
        for (int n = 0; n < 3000; n++) begin
            bit        av;
            bit [4:0]  ar;
            if (!lp_v && $urandom_range(0, 1) == 1) begin
                lp_v  = 1'b1;
                lp_rd = 5'($urandom_range(0, 7));
                lp_d  = $urandom;
            end
            av = $urandom_range(0, 1) == 1;
            ar = 5'($urandom_range(0, 7));
            step(av, ar, $urandom, lp_v, lp_rd, lp_d,
                 5'($urandom_range(0, 7)), acc);
            if (acc) lp_v = 1'b0;
        end
        idle(10, 0);
        chk("exp_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
